regfile_sequencer: RTL and testbench

//  Multi-cycle instruction sequencer that drives the 4x24-bit register file: reads operands via addr1/addr2,

---
 rtl/regfile_sequencer_pkg.sv | 43 ++++
 rtl/regfile_sequencer_alu24.sv | 56 +++++
 rtl/regfile_sequencer.sv | 122 ++++++++++++
 tb/tb_regfile_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_sequencer_pkg.sv
// Shared types for the register-file sequencer: opcodes, instruction layout,
// FSM states and datapath widths.
package regfile_sequencer_pkg;

  localparam int DATA_W = 24;
  localparam int ADDR_W = 2;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_MOV  = 4'h2,
    OP_ADD  = 4'h3,
    OP_SUB  = 4'h4,
    OP_AND  = 4'h5,
    OP_OR   = 4'h6,
    OP_XOR  = 4'h7,
    OP_SHL  = 4'h8,
    OP_SHR  = 4'h9,
    OP_CMP  = 4'hA,
    OP_HALT = 4'hF
  } opcode_t;

  typedef struct packed {
    opcode_t             opcode;
    logic [ADDR_W-1:0]   rd;
    logic [ADDR_W-1:0]   rs;
    logic [DATA_W-1:0]   imm;
  } instr_t;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    EXEC,
    WB,
    HALTED
  } seq_state_t;

  // Loads and moves are pure data transfers and keep the previous carry.
  function automatic logic updates_carry(opcode_t op);
    return !(op inside {OP_LDI, OP_MOV});
  endfunction

endpackage

// File: rtl/regfile_sequencer_alu24.sv
// Combinational 24-bit ALU: result, zero and carry/borrow for one opcode.
module alu24
  import regfile_sequencer_pkg::*;
(
  input  opcode_t             op,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [DATA_W-1:0]   imm,
  output logic [DATA_W-1:0]   result,
  output logic                z,
  output logic                c
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // The extra top bit of the difference is the unsigned borrow (a < b).
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    result = '0;
    c      = 1'b0;
    case (op)
      OP_LDI: result = imm;
      OP_MOV: result = b;
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        c      = sum[DATA_W];
      end
      OP_SUB, OP_CMP: begin
        result = diff[DATA_W-1:0];
        c      = diff[DATA_W];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: begin
        result = {a[DATA_W-2:0], 1'b0};
        c      = a[DATA_W-1];
      end
      OP_SHR: begin
        result = {1'b0, a[DATA_W-1:1]};
        c      = a[0];
      end
      default: begin
        result = '0;
        c      = 1'b0;
      end
    endcase
  end

  assign z = (result == '0);

endmodule

// File: rtl/regfile_sequencer.sv
// Serial instruction sequencer: READ -> EXEC -> WB over a 4x24 register file,
// one instruction every 4 cycles, sole writer of the register file.
module regfile_sequencer
  import regfile_sequencer_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [31:0]   instr,
  output logic [AW-1:0] rf_addr1,
  output logic [AW-1:0] rf_addr2,
  input  logic [DW-1:0] rf_rdata1,
  input  logic [DW-1:0] rf_rdata2,
  output logic [AW-1:0] rf_addr3,
  output logic          rf_write,
  output logic [DW-1:0] rf_wdata,
  output logic          result_valid,
  output logic [DW-1:0] result_data,
  output logic          flag_z,
  output logic          flag_c,
  output logic          halted,
  output logic          err_illegal
);

  seq_state_t        state;
  instr_t            ir;
  instr_t            instr_in;
  logic [DW-1:0]     op_a;
  logic [DW-1:0]     op_b;
  logic [DW-1:0]     result_q;
  logic              wb_q;
  logic              rv_q;
  logic [DW-1:0]     alu_result;
  logic              alu_z;
  logic              alu_c;

  assign instr_in = instr_t'(instr);

  alu24 u_alu (
    .op     (ir.opcode),
    .a      (op_a),
    .b      (op_b),
    .imm    (ir.imm),
    .result (alu_result),
    .z      (alu_z),
    .c      (alu_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ir          <= '0;
      op_a        <= '0;
      op_b        <= '0;
      result_q    <= '0;
      flag_z      <= 1'b0;
      flag_c      <= 1'b0;
      halted      <= 1'b0;
      err_illegal <= 1'b0;
      wb_q        <= 1'b0;
      rv_q        <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      wb_q <= 1'b0;
      rv_q <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid && instr_ready) begin
            ir <= instr_in;
            case (instr_in.opcode)
              OP_NOP: state <= IDLE;
              OP_HALT: begin
                state  <= HALTED;
                halted <= 1'b1;
              end
              OP_LDI, OP_MOV, OP_ADD, OP_SUB, OP_AND,
              OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_CMP: state <= READ;
              default: err_illegal <= 1'b1;
            endcase
          end
        end
        READ: begin
          op_a  <= rf_rdata1;
          op_b  <= rf_rdata2;
          state <= EXEC;
        end
        EXEC: begin
          result_q <= alu_result;
          flag_z   <= alu_z;
          if (updates_carry(ir.opcode)) flag_c <= alu_c;
          rv_q <= 1'b1;
          // CMP only produces flags, so it skips write-back entirely.
          if (ir.opcode == OP_CMP) begin
            state <= IDLE;
          end else begin
            state <= WB;
            wb_q  <= 1'b1;
          end
        end
        WB:      state <= IDLE;
        HALTED:  state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

  // Gating with reset keeps a write-back from landing while reset is applied.
  assign instr_ready  = (state == IDLE) && !reset;
  assign rf_write     = wb_q && !reset;
  assign result_valid = rv_q && !reset;
  assign rf_addr1     = ir.rd;
  assign rf_addr2     = ir.rs;
  assign rf_addr3     = ir.rd;
  assign rf_wdata     = result_q;
  assign result_data  = result_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Randomised self-checking bench for regfile_sequencer with a behavioural
// register file and an arithmetic reference model.
module tb_regfile_sequencer;

  localparam int DW = 24;
  localparam int AW = 2;
  localparam longint unsigned M = 64'd16777216;
  localparam logic [DW-1:0] R1_INIT = 24'h126728;
  localparam logic [DW-1:0] R2_INIT = 24'h884121;

  logic          clk = 1'b0;
  logic          reset;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr;
  logic [AW-1:0] rf_addr1, rf_addr2, rf_addr3;
  logic [DW-1:0] rf_rdata1, rf_rdata2, rf_wdata, result_data;
  logic          rf_write, result_valid, flag_z, flag_c, halted, err_illegal;

  logic [DW-1:0] rf [4];

  int tests  = 0;
  int errors = 0;

  longint unsigned m_rf [4];
  bit m_z, m_c, m_err, m_halt;

  always #5 clk = ~clk;

  regfile_sequencer #(.DW(DW), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .rf_addr1     (rf_addr1),
    .rf_addr2     (rf_addr2),
    .rf_rdata1    (rf_rdata1),
    .rf_rdata2    (rf_rdata2),
    .rf_addr3     (rf_addr3),
    .rf_write     (rf_write),
    .rf_wdata     (rf_wdata),
    .result_valid (result_valid),
    .result_data  (result_data),
    .flag_z       (flag_z),
    .flag_c       (flag_c),
    .halted       (halted),
    .err_illegal  (err_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rf[0] <= '0;
      rf[1] <= R1_INIT;
      rf[2] <= R2_INIT;
      rf[3] <= '0;
    end else if (rf_write) begin
      rf[rf_addr3] <= rf_wdata;
    end
  end

  assign rf_rdata1 = rf[rf_addr1];
  assign rf_rdata2 = rf[rf_addr2];

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_rf[0] = 0;
    m_rf[1] = longint'(R1_INIT);
    m_rf[2] = longint'(R2_INIT);
    m_rf[3] = 0;
    m_z = 0; m_c = 0; m_err = 0; m_halt = 0;
  endtask

  function automatic logic [95:0] model_regs();
    logic [DW-1:0] r0, r1, r2, r3;
    r0 = m_rf[0][DW-1:0]; r1 = m_rf[1][DW-1:0];
    r2 = m_rf[2][DW-1:0]; r3 = m_rf[3][DW-1:0];
    return {r0, r1, r2, r3};
  endfunction

  // Applies one instruction to the model; returns cycles until ready again
  // (0 = never), number of writes, number of result pulses and the result.
  task automatic model_step(input logic [31:0] w, output int lat, output int n_wr,
                            output int n_rv, output longint unsigned res);
    longint unsigned a, b, imm, r;
    int op;
    op  = int'(w[31:28]);
    a   = m_rf[w[27:26]];
    b   = m_rf[w[25:24]];
    imm = longint'(w[23:0]);
    r = 0; lat = 4; n_wr = 1; n_rv = 1;
    case (op)
      0:  begin lat = 1; n_wr = 0; n_rv = 0; end
      1:  r = imm;
      2:  r = b;
      3:  begin r = a + b; m_c = (r >= M); r = r % M; end
      4:  begin m_c = (a < b); r = (a + M - b) % M; end
      5:  begin r = a & b; m_c = 0; end
      6:  begin r = a | b; m_c = 0; end
      7:  begin r = a ^ b; m_c = 0; end
      8:  begin m_c = (a >= M / 2); r = (a * 2) % M; end
      9:  begin m_c = (a % 2 == 1); r = a / 2; end
      10: begin m_c = (a < b); r = (a + M - b) % M; lat = 3; n_wr = 0; end
      15: begin lat = 0; n_wr = 0; n_rv = 0; m_halt = 1; end
      default: begin lat = 1; n_wr = 0; n_rv = 0; m_err = 1; end
    endcase
    if (op >= 1 && op <= 10) m_z = (r == 0);
    if (n_wr == 1) m_rf[w[27:26]] = r;
    res = r;
  endtask

  // Called #1 after a rising edge; returns at the same phase.
  task automatic run_instr(input logic [31:0] w, input string tag);
    int lat, n_wr, n_rv, k, got_lat, wr_cnt, rv_cnt, waited;
    longint unsigned res;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd, rvd;
    logic [DW-1:0] exp_d;
    model_step(w, lat, n_wr, n_rv, res);
    exp_d = res[DW-1:0];
    waited = 0;
    while (!instr_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check({tag, "_ready"}, instr_ready, 1);
    instr_valid = 1'b1;
    instr       = w;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr       = $urandom;
    got_lat = 0; wr_cnt = 0; rv_cnt = 0; wa = '0; wd = '0; rvd = '0;
    for (k = 1; k <= 8; k++) begin
      if (rf_write) begin wr_cnt++; wa = rf_addr3; wd = rf_wdata; end
      if (result_valid) begin rv_cnt++; rvd = result_data; end
      if (instr_ready) begin got_lat = k; break; end
      @(posedge clk); #1;
    end
    check({tag, "_lat"}, got_lat, lat);
    check({tag, "_nwr"}, wr_cnt, n_wr);
    check({tag, "_nrv"}, rv_cnt, n_rv);
    if (n_wr == 1) begin
      check({tag, "_waddr"}, wa, w[27:26]);
      check({tag, "_wdata"}, wd, exp_d);
      check({tag, "_rdata"}, rvd, exp_d);
    end
    check({tag, "_flags"}, {flag_z, flag_c, err_illegal, halted}, {m_z, m_c, m_err, m_halt});
    check({tag, "_regs"}, {rf[0], rf[1], rf[2], rf[3]}, model_regs());
  endtask

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [1:0] rd,
                                     input logic [1:0] rs, input logic [23:0] imm);
    return {op, rd, rs, imm};
  endfunction

  initial begin
    logic [31:0] q [3];
    int acc [3];
    int idx, wr_cnt, exp_wr, lat, n_wr, n_rv, low_cnt;
    bit ready_hist [16];
    longint unsigned res;
    logic [31:0] w;

    reset = 1'b1; instr_valid = 1'b0; instr = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", instr_ready, 0);
    check("rst_outs", {rf_write, result_valid, flag_z, flag_c, halted, err_illegal}, 0);
    check("rst_result", result_data, 0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", instr_ready, 1);

    // Directed arithmetic scenarios
    run_instr(mk(4'h1, 2'd0, 2'd0, 24'h00000A), "ldi_r0");
    run_instr(mk(4'h3, 2'd0, 2'd1, 24'h0), "add_r0_r1");
    check("t1_r0", rf[0], 24'h126732);
    check("t1_flags", {flag_z, flag_c}, 2'b00);
    run_instr(mk(4'h3, 2'd2, 2'd2, 24'h0), "add_r2_r2");
    check("t2_r2_add", rf[2], 24'h108242);
    check("t2_c_add", flag_c, 1);
    run_instr(mk(4'h9, 2'd2, 2'd0, 24'h0), "shr_r2");
    check("t2_r2_shr", rf[2], 24'h084121);
    check("t2_c_shr", flag_c, 0);
    run_instr(mk(4'h4, 2'd3, 2'd1, 24'h0), "sub_r3_r1");
    check("t3_r3", rf[3], 24'hED98D8);
    check("t3_c", flag_c, 1);
    run_instr(mk(4'hA, 2'd1, 2'd1, 24'h0), "cmp_r1_r1");
    check("t3_cmp_z", flag_z, 1);

    // Back-to-back: instr_valid held high with three queued instructions
    q[0] = mk(4'h1, 2'd1, 2'd0, 24'h000100);
    q[1] = mk(4'h3, 2'd1, 2'd1, 24'h0);
    q[2] = mk(4'h7, 2'd0, 2'd1, 24'h0);
    idx = 0; wr_cnt = 0; exp_wr = 0;
    acc[0] = -1; acc[1] = -1; acc[2] = -1;
    for (int c = 0; c < 14; c++) begin
      instr_valid = (idx < 3);
      instr       = q[idx < 3 ? idx : 2];
      ready_hist[c] = instr_ready;
      if (rf_write) wr_cnt++;
      @(posedge clk);
      if (ready_hist[c] && idx < 3) begin
        acc[idx] = c;
        model_step(q[idx], lat, n_wr, n_rv, res);
        exp_wr += n_wr;
        idx++;
      end
      #1;
    end
    instr_valid = 1'b0;
    check("b2b_acc0", acc[0], 0);
    check("b2b_acc1", acc[1], 4);
    check("b2b_acc2", acc[2], 8);
    check("b2b_busy", {ready_hist[1], ready_hist[2], ready_hist[3]}, 3'b000);
    check("b2b_writes", wr_cnt, exp_wr);
    check("b2b_regs", {rf[0], rf[1], rf[2], rf[3]}, model_regs());

    // Randomised instruction stream (HALT excluded)
    for (int i = 0; i < 150; i++) begin
      w = mk(4'($urandom_range(0, 14)), 2'($urandom), 2'($urandom), 24'($urandom));
      if ($urandom_range(0, 7) == 0) w[23:0] = '0;
      run_instr(w, "rnd");
    end

    // Reset during EXEC of ADD r1,r2
    instr_valid = 1'b1;
    instr       = mk(4'h3, 2'd1, 2'd2, 24'h0);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("rst_exec_wr", rf_write, 0);
    @(posedge clk); #1;
    check("rst_exec_outs", {instr_ready, rf_write, result_valid, flag_z, flag_c, halted, err_illegal}, 0);
    check("rst_exec_result", result_data, 0);
    check("rst_exec_r1", rf[1], R1_INIT);
    reset = 1'b0;
    model_reset();
    #1;
    check("rst_exec_ready", instr_ready, 1);

    // Illegal opcode then a legal one: err_illegal stays set
    check("ill_pre", err_illegal, 0);
    run_instr(mk(4'hB, 2'd2, 2'd1, 24'h0), "illegal_b");
    check("ill_set", err_illegal, 1);
    run_instr(mk(4'h1, 2'd3, 2'd0, 24'h00ABCD), "ldi_after_ill");
    check("ill_sticky", err_illegal, 1);

    // HALT absorbs everything until reset
    run_instr(mk(4'hF, 2'd0, 2'd0, 24'h0), "halt");
    instr_valid = 1'b1;
    instr       = mk(4'h1, 2'd0, 2'd0, 24'h000055);
    low_cnt = 0; wr_cnt = 0;
    repeat (25) begin
      if (!instr_ready) low_cnt++;
      if (rf_write) wr_cnt++;
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    check("halt_ready_low", low_cnt, 25);
    check("halt_no_write", wr_cnt, 0);
    check("halt_held", halted, 1);
    check("halt_regs", {rf[0], rf[1], rf[2], rf[3]}, model_regs());
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("halt_cleared", {halted, err_illegal, instr_ready}, 3'b001);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
